// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin share of one combinational fp_division unit between two requesters.
// Latency: accept at edge E0 -> rspN_valid from the cycle after edge E0+DIV_CYCLES (result registered).
// Backpressure: one operation in flight; reqN_ready held low while busy, response held stable until rspN_ready.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/ready/in1/in2   requester N operation handshake and IEEE-754 single operands
//   rspN_valid/ready/out       requester N quotient handshake
//   div_in1/div_in2/div_out    connection to the shared combinational divider
//   busy                       registered (state != IDLE)
//   grant_id                   owner of the current or most recent operation
module fp_div_arbiter #(
    parameter int DIV_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out,

    output logic [31:0] div_in1,
    output logic [31:0] div_in2,
    input  logic [31:0] div_out,

    output logic        busy,
    output logic        grant_id
);

    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("fp_div_arbiter: DIV_CYCLES must be in 1..15");
    end

    // Settle counter value on the edge that captures div_out.
    localparam logic [3:0] CNT_LAST = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rr_ptr;
    logic [3:0]  cnt;
    logic [31:0] result;

    logic        winner;
    logic        accept;
    logic        cnt_done;
    logic        rsp_hs;

    // A lone valid requester always wins; the pointer only breaks ties.
    always_comb begin
        winner   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        cnt_done = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        rsp_hs     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_out   = '0;
        rsp1_out   = '0;
        case (state)
            IDLE: begin
                // rst_n gating keeps readies low for the whole reset window.
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = !winner;
                    req1_ready = winner;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp0_valid = rst_n && !grant_id;
                rsp1_valid = rst_n && grant_id;
                rsp0_out   = grant_id ? 32'd0 : result;
                rsp1_out   = grant_id ? result : 32'd0;
                rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Divider operands change only on an accept edge, so the divider sees
    // constant inputs for the whole settle window and beyond.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            rr_ptr   <= 1'b0;
            grant_id <= 1'b0;
            cnt      <= '0;
            div_in1  <= '0;
            div_in2  <= '0;
            result   <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (accept) begin
                div_in1  <= winner ? req1_in1 : req0_in1;
                div_in2  <= winner ? req1_in2 : req0_in2;
                grant_id <= winner;
                rr_ptr   <= !winner;
                cnt      <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
                if (cnt_done) begin
                    result <= div_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
module tb_fp_div_arbiter;

    localparam int DIV_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  dv;
    logic [1:0]  dr;
    logic [31:0] da [2];
    logic [31:0] db [2];

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id;
    logic [31:0] rsp0_out, rsp1_out, div_in1, div_in2, div_out;

    always #5 clk = ~clk;

    fp_div_arbiter #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (dv[0]),
        .req0_ready (req0_ready),
        .req0_in1   (da[0]),
        .req0_in2   (db[0]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (dr[0]),
        .rsp0_out   (rsp0_out),
        .req1_valid (dv[1]),
        .req1_ready (req1_ready),
        .req1_in1   (da[1]),
        .req1_in2   (db[1]),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (dr[1]),
        .rsp1_out   (rsp1_out),
        .div_in1    (div_in1),
        .div_in2    (div_in2),
        .div_out    (div_out),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // ---------------- single-precision division via real arithmetic ----------------
    function automatic real s2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'({3'b000, x[30:23]}) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Round-to-nearest-even from double; operands are kept in the normal range.
    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [31:0] s;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        s = {d[63], e[7:0], d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) s[30:0] = s[30:0] + 31'd1;
        return s;
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) / s2r(b));
    endfunction

    // Stand-in for the shared combinational fp_division unit.
    always_comb begin
        if (div_in2[30:0] == 31'd0) div_out = 32'd0;
        else                         div_out = ref_div(div_in1, div_in2);
    end

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(110, 145));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference model: one operation in flight, response DIV_CYCLES cycles after accept.
    bit          m_out = 0;
    bit          m_id = 0;
    bit          m_rr = 0;
    bit          m_grant = 0;
    int          m_age = 0;
    logic [31:0] m_val = '0;
    logic [31:0] m_d1 = '0;
    logic [31:0] m_d2 = '0;

    // Per-cycle events/samples for the directed sequences.
    bit          acc;
    bit          acc_id;
    logic [1:0]  rdy;
    logic [1:0]  rv;
    logic [31:0] s_out0, s_out1, s_d1, s_d2;
    logic        s_grant;

    // Called at a falling edge after inputs are driven; returns at the next falling edge.
    task automatic cycle();
        logic [1:0] exp_rdy;
        logic [1:0] exp_vld;
        logic       w;
        #1;
        rdy = {req1_ready, req0_ready};
        rv = {rsp1_valid, rsp0_valid};
        s_out0 = rsp0_out;
        s_out1 = rsp1_out;
        s_d1 = div_in1;
        s_d2 = div_in2;
        s_grant = grant_id;

        exp_rdy = 2'b00;
        exp_vld = 2'b00;
        w = 1'b0;
        if (rst_n && !m_out && dv != 2'b00) begin
            w = (dv == 2'b11) ? m_rr : dv[1];
            exp_rdy[w] = 1'b1;
        end
        if (m_out && m_age >= DIV_CYCLES) exp_vld[m_id] = 1'b1;

        chk1("req0_ready", req0_ready, exp_rdy[0]);
        chk1("req1_ready", req1_ready, exp_rdy[1]);
        if (rst_n || !m_out) begin
            chk1("rsp0_valid", rsp0_valid, exp_vld[0]);
            chk1("rsp1_valid", rsp1_valid, exp_vld[1]);
            chk("rsp0_out", rsp0_out, exp_vld[0] ? m_val : 32'd0);
            chk("rsp1_out", rsp1_out, exp_vld[1] ? m_val : 32'd0);
        end
        chk1("busy", busy, m_out);
        chk1("grant_id", grant_id, m_grant);
        chk("div_in1", div_in1, m_d1);
        chk("div_in2", div_in2, m_d2);

        acc = 0;
        if (!rst_n) begin
            m_out = 0; m_rr = 0; m_grant = 0; m_d1 = '0; m_d2 = '0; m_age = 0;
        end else begin
            if (m_out) m_age++;
            if (exp_rdy != 2'b00) begin
                m_out = 1; m_age = 0; m_id = w; m_grant = w; m_rr = !w;
                m_d1 = da[w]; m_d2 = db[w]; m_val = ref_div(da[w], db[w]);
                acc = 1; acc_id = w;
            end else if (exp_vld != 2'b00 && dr[m_id]) begin
                m_out = 0;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs cycles until requester id completes a response handshake.
    task automatic wait_hs(input bit id, output logic [31:0] res, output int acc_c,
                           output int vld_c, output int nrdy, output bit ok);
        res = '0; acc_c = -1; vld_c = -1; nrdy = 0; ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cycle();
            if (acc) dv[acc_id] = 1'b0;
            if (rdy[id]) begin
                nrdy++;
                if (acc_c < 0) acc_c = cyc;
            end
            if (rv[id] && vld_c < 0) vld_c = cyc;
            if (rv[id] && dr[id]) begin
                res = id ? s_out1 : s_out0;
                ok = 1;
            end
        end
        chk1("handshake_within_budget", ok, 1'b1);
    endtask

    task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int nrdy);
        int  acc_c, vld_c;
        bit  ok;
        dv[id] = 1'b1; da[id] = a; db[id] = b; dr[id] = 1'b1;
        wait_hs(id, res, acc_c, vld_c, nrdy, ok);
        lat = vld_c - acc_c;
    endtask

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] res;
        int          lat, nrdy, n_hs, n_g, n_v;
        logic        ord [2];
        logic [31:0] got [2];
        logic        gid [2];
        bit          seen;

        vecs[0] = '{id: 1'b0, a: 32'h41000000, b: 32'h40000000, q: 32'h40800000}; // 8/2
        vecs[1] = '{id: 1'b1, a: 32'h3F800000, b: 32'h40400000, q: 32'h3EAAAAAB}; // 1/3
        vecs[2] = '{id: 1'b0, a: 32'hC0C00000, b: 32'h3FC00000, q: 32'hC0800000}; // -6/1.5
        vecs[3] = '{id: 1'b1, a: 32'h40490FDB, b: 32'h40490FDB, q: 32'h3F800000}; // pi/pi
        vecs[4] = '{id: 1'b0, a: 32'h3F800000, b: 32'h41200000, q: 32'h3DCCCCCD}; // 1/10
        vecs[5] = '{id: 1'b1, a: 32'h42F60000, b: 32'hC1000000, q: 32'hC1760000}; // 123/-8

        rst_n = 1'b0; dr = 2'b00;
        dv = 2'b11;
        da[0] = 32'h41700000; db[0] = 32'h40A00000; // 15/5
        da[1] = 32'h42C80000; db[1] = 32'h41C80000; // 100/25
        @(negedge clk);

        // Reset held with both valid: nothing accepted, divider inputs zero.
        repeat (3) cycle();

        // Contention straight out of reset.
        rst_n = 1'b1; dr = 2'b11;
        n_hs = 0; n_g = 0;
        ord[0] = 1'b1; ord[1] = 1'b0; got[0] = '0; got[1] = '0; gid[0] = 1'b1; gid[1] = 1'b0;
        for (int i = 0; i < 40 && n_hs < 2; i++) begin
            cycle();
            if (acc) dv[acc_id] = 1'b0;
            if (rdy != 2'b00 && n_g < 2) begin ord[n_g] = rdy[1]; n_g++; end
            if (rv != 2'b00) begin
                got[n_hs] = rv[1] ? s_out1 : s_out0;
                gid[n_hs] = s_grant;
                n_hs++;
            end
        end
        chk("contention_responses", n_hs, 2);
        chk1("contention_first_grant", ord[0], 1'b0);
        chk1("contention_second_grant", ord[1], 1'b1);
        chk("contention_result0", got[0], 32'h40400000);
        chk("contention_result1", got[1], 32'h40800000);
        chk1("contention_grant_id0", gid[0], 1'b0);
        chk1("contention_grant_id1", gid[1], 1'b1);

        // Table-driven single requests.
        for (int k = 0; k < 6; k++) begin
            run_op(vecs[k].id, vecs[k].a, vecs[k].b, res, lat, nrdy);
            chk("table_quotient", res, vecs[k].q);
            chk("table_latency", lat, DIV_CYCLES + 1);
            chk("table_ready_pulses", nrdy, 1);
        end

        // Backpressure on requester 1; requester 0 waits with changing operands.
        dr = 2'b00; dv = 2'b10;
        da[1] = 32'h41100000; db[1] = 32'h40400000; // 9/3
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (acc) dv[acc_id] = 1'b0;
            if (rv[1]) seen = 1;
        end
        chk1("bp_rsp1_valid_seen", seen, 1'b1);
        dv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            da[0] = rnd_fp(); db[0] = rnd_fp();
            cycle();
            chk1("bp_rsp1_valid_held", rv[1], 1'b1);
            chk("bp_rsp1_out_held", s_out1, 32'h40400000);
            chk1("bp_req0_blocked", rdy[0], 1'b0);
            chk("bp_div_in1_stable", s_d1, 32'h41100000);
            chk("bp_div_in2_stable", s_d2, 32'h40400000);
        end
        da[0] = 32'h40000000; db[0] = 32'h40800000; // 2/4
        dr = 2'b11;
        cycle();
        chk1("bp_handshake_cycle_valid", rv[1], 1'b1);
        chk1("bp_req0_not_accepted_at_hs", rdy[0], 1'b0);
        cycle();
        if (acc) dv[acc_id] = 1'b0;
        chk1("bp_req0_accepted_after_hs", rdy[0], 1'b1);
        begin
            int  a_c, v_c;
            bit  ok;
            wait_hs(1'b0, res, a_c, v_c, nrdy, ok);
        end
        chk("bp_req0_result", res, 32'h3F000000);

        // Reset one cycle after accept drops the operation.
        dv[0] = 1'b1; da[0] = 32'h41000000; db[0] = 32'h40000000;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (acc) dv[acc_id] = 1'b0;
            if (rdy[0]) seen = 1;
        end
        chk1("rst_wait_accepted", seen, 1'b1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_v = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (rv != 2'b00) n_v++;
        end
        chk("rst_wait_no_response", n_v, 0);
        run_op(1'b0, 32'h3F800000, 32'h40400000, res, lat, nrdy);
        chk("rst_wait_next_result", res, 32'h3EAAAAAB);

        // Fairness: both continuously valid from a fresh pointer.
        rst_n = 1'b0; dv = 2'b00;
        cycle();
        rst_n = 1'b1; dr = 2'b11; dv = 2'b11;
        for (int r = 0; r < 2; r++) begin da[r] = rnd_fp(); db[r] = rnd_fp(); end
        n_g = 0;
        for (int i = 0; i < 80 && n_g < 6; i++) begin
            cycle();
            if (rdy != 2'b00) begin
                chk1("fair_grant_order", rdy[1], (n_g % 2) == 1);
                n_g++;
            end
            if (acc) begin da[acc_id] = rnd_fp(); db[acc_id] = rnd_fp(); end
        end
        chk("fair_grant_count", n_g, 6);
        dv = 2'b00;
        repeat (DIV_CYCLES + 3) cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!dv[r] && $urandom_range(0, 2) == 0) begin
                    dv[r] = 1'b1; da[r] = rnd_fp(); db[r] = rnd_fp();
                end else if (dv[r] && $urandom_range(0, 7) == 0) begin
                    da[r] = rnd_fp();
                end
                dr[r] = ($urandom_range(0, 3) != 0);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
            if (acc) dv[acc_id] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Shares one combinational `fp_division` unit between two requesters over valid/ready handshakes. Round-robin arbitration picks one request at a time and registers its operands onto the divider inputs. The block holds them for a fixed multicycle settle window, then registers the quotient and returns it to the winning requester. It sits between the FP ALU front-end clients and the single divider instance.

## Interface
- `DIV_CYCLES`, 2, cycles allowed for the divider to settle, treated as a multicycle path; legal range 1..15.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req0_valid` input 1: requester 0 presents an operation.
- `req0_ready` output 1: requester 0 operation accepted this cycle.
- `req0_in1` input 32: requester 0 dividend, IEEE-754 single precision.
- `req0_in2` input 32: requester 0 divisor, IEEE-754 single precision.
- `rsp0_valid` output 1: result available for requester 0.
- `rsp0_ready` input 1: requester 0 takes the result.
- `rsp0_out` output 32: quotient for requester 0.
- `req1_*`, `rsp1_*`: same as the requester 0 ports, for requester 1.
- `div_in1` output 32: dividend driven to the `fp_division` `in1` input.
- `div_in2` output 32: divisor driven to the `fp_division` `in2` input.
- `div_out` input 32: quotient from `fp_division` `out`.
- `busy` output 1: high in any state other than IDLE.
- `grant_id` output 1: owner of the current or most recent operation.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE, winner selection:**
  - Only one request valid: that requester wins.
  - Both valid: the requester indicated by the round-robin pointer `rr_ptr` wins.
- **IDLE, accept:**
  - `reqN_ready` is asserted combinationally only for the winner and only while its valid is high; the other ready stays 0.
  - On an accept edge: the winner's in1/in2 are registered into `div_in1`/`div_in2`, `grant_id` is set to the winner, `rr_ptr` is set to the other requester, the settle counter is set to 0, and the FSM moves to WAIT.
- **WAIT:**
  - The counter increments every cycle.
  - When the counter reaches `DIV_CYCLES`−1, `div_out` is registered into the result register on that edge and the FSM moves to RESP.
  - Counter width is 4 bits.
- **RESP:**
  - `rsp{grant_id}_valid` is 1 and `rsp{grant_id}_out` equals the result register. The other requester's valid is 0, and its out is 0.
  - Valid and data stay stable until ready.
  - Handshake edge (valid and ready both high): the FSM moves to IDLE. `rr_ptr` is not changed.
- `div_in1`/`div_in2` hold their values through WAIT, RESP and the following IDLE, until the next accept. The divider input never toggles mid-settle.
- Requests arriving during WAIT/RESP are not accepted (ready stays 0). They must be held by the requester; no buffering.
- The block passes the divider result through without altering it: no NaN, infinity or divide-by-zero handling.

## Timing
- Reset (`rst_n`=0 at an edge):
  - FSM goes to IDLE; `rr_ptr`, `grant_id`, counter, `div_in1`, `div_in2` and the result register all go to 0.
  - All valid/ready outputs are 0 and `busy` is 0.
  - Reset mid-WAIT or mid-RESP drops the operation silently; no response is issued.
  - While `rst_n` is low, ready outputs are forced to 0.
- Latency: accept at edge E0 → `rsp_valid` high from the cycle after edge E0+`DIV_CYCLES`. With `DIV_CYCLES`=2, `rsp_valid` rises two cycles after accept.
- Back-to-back operations: response handshake at edge Er puts the FSM in IDLE in the next cycle. The earliest next accept is at edge Er+1.
  - Minimum initiation interval is `DIV_CYCLES`+2 cycles when `rsp_ready` is held high.
- Simultaneous events:
  - Both valid in IDLE: `rr_ptr` decides.
  - A request valid in the same cycle as a RESP handshake is not accepted in that cycle.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- `busy` equals (state≠IDLE), registered.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with both valids high → all readies, valids and `busy` stay 0; `div_in1`=`div_in2`=0.
- **Single request, requester 0:** 8.0/2.0 (0x41000000/0x40000000) with `DIV_CYCLES`=2 → `req0_ready` pulses once; `rsp0_valid` rises 2 cycles later with `rsp0_out`=0x40800000; `rsp1_valid` stays 0.
- **Contention:** both requesters valid from reset. Requester 0 sends 15.0/5.0 (0x41700000/0x40A00000); requester 1 sends 100.0/25.0 (0x42C80000/0x41C80000) → requester 0 is served first and gets 0x40400000, then requester 1 gets 0x40800000. `grant_id` sequence is 0,1.
- **Backpressure:** hold `rsp1_ready`=0 for 5 cycles in RESP → `rsp1_valid`/`rsp1_out` stay stable; a new `req0_valid` is not accepted until 1 cycle after the `rsp1` handshake.
- **Stable divider inputs:** during WAIT, change `req0_in1`/`req0_in2` while valid → `div_in1`/`div_in2` unchanged until the next accept.
- **Reset mid-WAIT:** assert `rst_n`=0 one cycle after accept → no `rsp_valid` ever appears for that operation; the next request, 1.0/3.0 (0x3F800000/0x40400000), completes normally with result 0x3EAAAAAB.
